// File: rtl/cycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: phase states, regbank
// write-source code for loads, and small decode helpers.
package cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_FETCH     = 3'd1,
    SEQ_DECODE    = 3'd2,
    SEQ_EXECUTE   = 3'd3,
    SEQ_MEMORY    = 3'd4,
    SEQ_WRITEBACK = 3'd5,
    SEQ_HALT      = 3'd6
  } seq_state_e;

  // Regbank write source selecting RAM read data.
  localparam logic [1:0] REGSRC_LOAD = 2'd1;

  // An instruction needs the MEMORY phase if it stores or loads.
  function automatic logic is_mem_op(input logic ramconfig, input logic [1:0] regsource);
    return ramconfig | (regsource == REGSRC_LOAD);
  endfunction

  // Busy covers every phase of an instruction in flight.
  function automatic logic is_busy_state(input seq_state_e s);
    return (s != SEQ_IDLE) && (s != SEQ_HALT);
  endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control/datapath handshake bundle around the sequencer. The master side
// is the control_unit/datapath environment, the slave side is the sequencer.
interface cycle_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             halt_req;
  logic [WIDTH-1:0] instruction;
  logic             ramconfig;
  logic             regbankconfig;
  logic [1:0]       regsource;
  logic             mem_ready;
  logic [2:0]       state;
  logic             ir_load;
  logic             pc_enable;
  logic             ram_wenable;
  logic             regbank_wenable;
  logic             mem_req;
  logic             busy;
  logic             halted;
  logic             fault;
  logic [WIDTH-1:0] retired;

  modport master (
    output start, halt_req, instruction, ramconfig, regbankconfig, regsource, mem_ready,
    input  state, ir_load, pc_enable, ram_wenable, regbank_wenable, mem_req, busy,
           halted, fault, retired
  );

  modport slave (
    input  start, halt_req, instruction, ramconfig, regbankconfig, regsource, mem_ready,
    output state, ir_load, pc_enable, ram_wenable, regbank_wenable, mem_req, busy,
           halted, fault, retired
  );
endinterface

// File: rtl/cycle_sequencer_mem_watchdog.sv
// Memory watchdog: counts cycles while count is high, saturating at
// MEM_TIMEOUT; expired flags the saturated value. clear wins over count.
module cycle_sequencer_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] value_q;
  logic [CW-1:0] value_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = {CW{1'b0}};
    end else if (count && (value_q != LIMIT)) begin
      value_d = value_q + CW'(1);
    end else begin
      value_d = value_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= {CW{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign expired = (value_q == LIMIT);

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK, gates PC and write enables to
// a single phase, handles halt requests, retire counting and the memory
// watchdog fault.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      MEM_TIMEOUT = 15,
  parameter logic [WIDTH-1:0] HALT_OPCODE = {WIDTH{1'b1}}
) (
  input logic              clock,
  input logic              reset,
  cycle_sequencer_if.slave bus
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic             halt_pend_q;
  logic             fault_q;
  logic             ir_load_q;
  logic             pc_enable_q;
  logic             regbank_we_q;
  logic             mem_req_q;
  logic             busy_q;
  logic             halted_q;
  logic [WIDTH-1:0] retired_q;

  logic             busy_s;
  logic             halt_now_s;
  logic             halt_op_s;
  logic             wd_count_s;
  logic             wd_clear_s;
  logic             wd_expired_s;
  logic             fault_set_s;

  assign busy_s     = is_busy_state(state_q);
  assign halt_op_s  = (bus.instruction == HALT_OPCODE);
  // A request arriving in WRITEBACK itself is honoured there as well.
  assign halt_now_s = halt_pend_q | bus.halt_req;
  // The watchdog counts on the edge into each MEMORY cycle, so its value
  // equals the number of MEMORY cycles spent so far.
  assign wd_count_s = (state_d == SEQ_MEMORY);
  assign wd_clear_s = ~wd_count_s;
  assign fault_set_s = (state_q == SEQ_MEMORY) & ~bus.mem_ready & wd_expired_s;

  cycle_sequencer_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear_s),
    .count   (wd_count_s),
    .expired (wd_expired_s)
  );

  // Next-phase selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: begin
        if (bus.start) state_d = SEQ_FETCH;
        else           state_d = SEQ_IDLE;
      end
      SEQ_FETCH:   state_d = SEQ_DECODE;
      SEQ_DECODE:  state_d = SEQ_EXECUTE;
      SEQ_EXECUTE: begin
        if (is_mem_op(bus.ramconfig, bus.regsource)) state_d = SEQ_MEMORY;
        else                                         state_d = SEQ_WRITEBACK;
      end
      SEQ_MEMORY: begin
        if (bus.mem_ready)      state_d = SEQ_WRITEBACK;
        else if (wd_expired_s)  state_d = SEQ_HALT;
        else                    state_d = SEQ_MEMORY;
      end
      SEQ_WRITEBACK: begin
        if (halt_op_s || halt_now_s) state_d = SEQ_HALT;
        else                         state_d = SEQ_FETCH;
      end
      SEQ_HALT: begin
        if (bus.start) state_d = SEQ_FETCH;
        else           state_d = SEQ_HALT;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State, registered phase outputs, halt-pending, fault and retire count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SEQ_IDLE;
      halt_pend_q  <= 1'b0;
      fault_q      <= 1'b0;
      ir_load_q    <= 1'b0;
      pc_enable_q  <= 1'b0;
      regbank_we_q <= 1'b0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      retired_q    <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      ir_load_q    <= (state_d == SEQ_FETCH);
      pc_enable_q  <= (state_d == SEQ_WRITEBACK);
      regbank_we_q <= (state_d == SEQ_WRITEBACK) & bus.regbankconfig & ~halt_op_s;
      mem_req_q    <= (state_d == SEQ_MEMORY);
      busy_q       <= is_busy_state(state_d);
      halted_q     <= (state_d == SEQ_HALT);

      if (fault_set_s) fault_q <= 1'b1;
      else             fault_q <= fault_q;

      if (state_q == SEQ_WRITEBACK) retired_q <= retired_q + WIDTH'(1);
      else                          retired_q <= retired_q;

      // start out of HALT discards any request seen in the same cycle.
      if ((state_q == SEQ_HALT) && bus.start)                        halt_pend_q <= 1'b0;
      else if ((state_q == SEQ_WRITEBACK) && (state_d == SEQ_HALT))  halt_pend_q <= 1'b0;
      else if (busy_s && bus.halt_req)                               halt_pend_q <= 1'b1;
      else                                                           halt_pend_q <= halt_pend_q;
    end
  end

  assign bus.state           = state_q;
  assign bus.ir_load         = ir_load_q;
  assign bus.pc_enable       = pc_enable_q;
  assign bus.regbank_wenable = regbank_we_q & ~reset;
  assign bus.ram_wenable     = (state_q == SEQ_MEMORY) & bus.ramconfig & bus.mem_ready & ~reset;
  assign bus.mem_req         = mem_req_q;
  assign bus.busy            = busy_q;
  assign bus.halted          = halted_q;
  assign bus.fault           = fault_q;
  assign bus.retired         = retired_q;

endmodule
